cache_mem_arbiter: RTL and testbench

//  Shares the single core-to-memory port between the instruction-cache refill

---
 rtl/cache_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single core-to-memory port between the icache refill path
//   (read only) and the dcache refill/writeback path (read or write).
//   Round-robin arbitration; each cache line is split into LINE_W/MEM_W beats
//   and, on reads, the returned beats are reassembled into a full line.
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   i_req, i_addr               icache line read request, held until i_done
//   i_done, i_rdata             one-cycle completion pulse / assembled line
//   d_req, d_we, d_addr,        dcache line request (we/wdata sampled at
//   d_wdata                     grant), held until d_done
//   d_done, d_rdata             one-cycle completion pulse / assembled line
//   mem_valid, mem_we,          beat command, accepted on mem_valid & mem_ready
//   mem_addr, mem_wdata,
//   mem_ready
//   mem_rvalid, mem_rdata       in-order read beat return
//   caches_stall                high while either cache still waits on its line
module cache_mem_arbiter #(
    parameter int ADDR_W = 36,
    parameter int LINE_W = 512,
    parameter int MEM_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MEM_W-1:0]  mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic              caches_stall
);

    localparam int BEATS   = LINE_W / MEM_W;
    localparam int IDX_W   = $clog2(BEATS);
    localparam int CNT_W   = IDX_W + 1;
    localparam int OFF_W   = $clog2(LINE_W / 8);
    localparam int BEAT_SH = $clog2(MEM_W / 8);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_i_q;   // 1: icache owns the current transaction
    logic              last_i_q;    // 1: last grant went to the icache
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [LINE_W-1:0] line_q;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  rcvd_q, rcvd_d;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

    logic              grant_v, grant_i;
    logic              xfer_active, beat_acc, beat_ret;
    logic [ADDR_W-1:0] grant_addr;
    logic              unused_addr_bits;

    // Tie: serve whoever did not get the previous grant.
    assign grant_v     = (state_q == IDLE) && (i_req || d_req);
    assign grant_i     = i_req && (!d_req || !last_i_q);
    assign grant_addr  = grant_i ? i_addr : d_addr;

    assign xfer_active = (state_q == XFER) && (issued_q < BEATS_C);
    assign beat_acc    = xfer_active && mem_ready;
    // Returns outside a read transfer (or beyond the line) are dropped.
    assign beat_ret    = (state_q == XFER) && !we_q && mem_rvalid && (rcvd_q < BEATS_C);

    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and counter next values. Exit uses the post-edge counts so a
    // beat accepted (and returned) in the last XFER cycle goes straight to DONE.
    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        rcvd_d   = rcvd_q;
        if (grant_v) begin
            issued_d = '0;
            rcvd_d   = '0;
        end else begin
            if (beat_acc) issued_d = issued_q + 1'b1;
            if (beat_ret) rcvd_d   = rcvd_q + 1'b1;
        end
        unique case (state_q)
            IDLE:    if (grant_v) state_d = XFER;
            XFER:    if (issued_d == BEATS_C && (we_q || rcvd_d == BEATS_C)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers.
    // NOTE: the line-wide buffers are reset on purpose: i_rdata/d_rdata are
    // outputs that must read 0 out of reset, not uninitialised storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_i_q <= 1'b0;
            last_i_q  <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            line_q    <= '0;
            issued_q  <= '0;
            rcvd_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            if (grant_v) begin
                owner_i_q <= grant_i;
                last_i_q  <= grant_i;
                we_q      <= !grant_i && d_we;
                base_q    <= {grant_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                line_q    <= d_wdata;
            end
            if (beat_ret) begin
                if (owner_i_q) i_rdata_q[int'(rcvd_q[IDX_W-1:0]) * MEM_W +: MEM_W] <= mem_rdata;
                else           d_rdata_q[int'(rcvd_q[IDX_W-1:0]) * MEM_W +: MEM_W] <= mem_rdata;
            end
        end
    end

    // Outputs. Command fields come only from registers, so they stay stable
    // while the memory holds mem_ready low.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer_active) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_q + (ADDR_W'(issued_q) << BEAT_SH);
            if (we_q) mem_wdata = line_q[int'(issued_q[IDX_W-1:0]) * MEM_W +: MEM_W];
        end
        i_done = (state_q == DONE) && owner_i_q;
        d_done = (state_q == DONE) && !owner_i_q;
    end

    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign caches_stall = !rst && ((i_req && !i_done) || (d_req && !d_done));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    typedef struct {
        logic          we;
        logic [35:0]   addr;
        logic [127:0]  wdata;
    } beat_t;

    typedef struct {
        logic [35:0] addr;
        int          due;
    } ret_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, d_req, d_we;
    logic [35:0]  i_addr, d_addr;
    logic [511:0] d_wdata;
    logic         i_done, d_done;
    logic [511:0] i_rdata, d_rdata;
    logic         mem_valid, mem_we, mem_ready, mem_rvalid, caches_stall;
    logic [35:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    cache_mem_arbiter #(.ADDR_W(36), .LINE_W(512), .MEM_W(128)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .caches_stall(caches_stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model: sparse storage, unwritten lines return an address hash.
    logic [127:0] mem_arr [logic [35:0]];
    beat_t        log_q[$];
    ret_t         rq[$];
    int           cyc = 0;
    int           last_acc = 0, last_ret = 0;
    bit           ready_rand = 0, ret_rand = 0, hold_ret = 0, stray_rv = 0;
    int           stall_beat = -1, stall_left = 0;
    int           hold_bad = 0, stall_seen = 0;

    // Reference state kept by the bench.
    logic [511:0] exp_i = '0, exp_d = '0;
    bit           last_i = 0;
    logic [35:0]  pool [4] = '{36'h0_0000_1000, 36'h8_0000_0040, 36'hF_FFFF_FFC0, 36'h1_2345_6780};

    function automatic logic [127:0] mem_word(input logic [35:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0], 32'hFACE_0000 | 32'(a[19:4]), a[31:0]};
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: drives ready/rvalid between edges, logs accepted beats.
    initial begin
        logic        rdy, prev_stall, prev_we;
        logic [35:0] prev_addr;
        logic [127:0] prev_wdata;
        beat_t       b;
        ret_t        r;
        prev_stall = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ready = 0; mem_rvalid = 0; prev_stall = 0;
            end else begin
                rdy = 1'b1;
                if (ready_rand) rdy = ($urandom_range(3) != 0);
                if (mem_valid && stall_left > 0 && log_q.size() == stall_beat) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                mem_ready = rdy;
                if (prev_stall && (mem_valid !== 1'b1 || mem_addr !== prev_addr ||
                                   mem_wdata !== prev_wdata || mem_we !== prev_we))
                    hold_bad++;
                prev_stall = mem_valid && !rdy;
                prev_addr = mem_addr; prev_wdata = mem_wdata; prev_we = mem_we;
                if (prev_stall) stall_seen++;
                if (mem_valid && rdy) begin
                    b.we = mem_we; b.addr = mem_addr; b.wdata = mem_wdata;
                    log_q.push_back(b);
                    last_acc = cyc;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    else begin
                        r.addr = mem_addr;
                        r.due  = cyc + (ret_rand ? int'($urandom_range(3)) : 0);
                        rq.push_back(r);
                    end
                end
                if (!hold_ret && rq.size() > 0 && rq[0].due <= cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(rq[0].addr);
                    void'(rq.pop_front());
                    last_ret = cyc;
                end else begin
                    mem_rvalid = stray_rv;
                    mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for the owner's done pulse and checks the whole transaction.
    task automatic serve(input bit is_i, input logic [35:0] addr, input bit we,
                         input logic [511:0] wd, input int exp_lat);
        logic [35:0]  base;
        logic [511:0] line;
        int           n, ev;
        bit           seen, stall_bad;
        base = {addr[35:6], 6'b0};
        n = 0; seen = 0; stall_bad = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (i_done || d_done) seen = 1;
            else if (caches_stall !== (i_req || d_req)) stall_bad = 1;
        end
        check("done_seen", 512'(seen), 512'(1));
        if (seen) begin
            check("done_i", 512'(i_done), 512'(is_i));
            check("done_d", 512'(d_done), 512'(!is_i));
            check("stall_done", 512'(caches_stall), 512'(is_i ? d_req : i_req));
            check("stall_wait", 512'(stall_bad), 512'(0));
            if (exp_lat > 0) check("latency", 512'(n), 512'(exp_lat));
            check("beat_count", 512'(log_q.size()), 512'(4));
            for (int k = 0; k < 4 && k < log_q.size(); k++) begin
                check($sformatf("beat%0d_addr", k), 512'(log_q[k].addr), 512'(base + 36'(k * 16)));
                check($sformatf("beat%0d_we", k), 512'(log_q[k].we), 512'(we));
                if (we) check($sformatf("beat%0d_wdata", k), 512'(log_q[k].wdata), 512'(wd[k*128 +: 128]));
            end
            ev = (!we && last_ret > last_acc) ? last_ret : last_acc;
            check("done_timing", 512'(cyc), 512'(ev + 1));
            if (!we) begin
                for (int k = 0; k < 4; k++) line[k*128 +: 128] = mem_word(base + 36'(k * 16));
                if (is_i) exp_i = line;
                else      exp_d = line;
            end
            check("i_rdata", i_rdata, exp_i);
            check("d_rdata", d_rdata, exp_d);
            last_i = is_i;
        end
        log_q.delete();
        @(posedge clk);
        #1;
        if (is_i) i_req = 0;
        else      d_req = 0;
        @(negedge clk);
        check("done_pulse", 512'(i_done || d_done), 512'(0));
    endtask

    initial begin
        logic [35:0]  a1, a2;
        logic [511:0] wd;
        int           n;
        bit           early;

        rst = 1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_i_done", 512'(i_done), 512'(0));
        check("rst_d_done", 512'(d_done), 512'(0));
        check("rst_mem_valid", 512'(mem_valid), 512'(0));
        check("rst_mem_addr", 512'(mem_addr), 512'(0));
        check("rst_mem_wdata", 512'(mem_wdata), 512'(0));
        check("rst_i_rdata", i_rdata, 512'(0));
        check("rst_d_rdata", d_rdata, 512'(0));
        check("rst_stall", 512'(caches_stall), 512'(0));
        rst = 0;
        @(negedge clk);

        // Simultaneous requests after reset: icache first, then dcache.
        a1 = 36'h0_0000_2000; a2 = 36'h0_0000_3010;
        i_addr = a1; d_addr = a2; d_we = 0; i_req = 1; d_req = 1;
        serve(1, a1, 0, '0, 0);
        serve(0, a2, 0, '0, 0);

        // Lone icache read at minimum latency, known beat data.
        mem_arr[36'h1040] = 128'hA; mem_arr[36'h1050] = 128'hB;
        mem_arr[36'h1060] = 128'hC; mem_arr[36'h1070] = 128'hD;
        i_addr = 36'h0_0000_1047; i_req = 1;
        serve(1, 36'h0_0000_1047, 0, '0, 5);
        check("t1_line", i_rdata, {128'hD, 128'hC, 128'hB, 128'hA});

        // Simultaneous again with last grant = I: dcache first.
        a1 = 36'h0_0000_4000; a2 = 36'h0_0000_5000;
        i_addr = a1; d_addr = a2; d_we = 0; i_req = 1; d_req = 1;
        serve(0, a2, 0, '0, 0);
        serve(1, a1, 0, '0, 0);

        // Writeback with memory stalling two cycles on beat 1.
        wd = {128'h3333_0000_0000_0000_0000_0000_0000_0003, 128'h2222_0000_0000_0000_0000_0000_0000_0002,
              128'h1111_0000_0000_0000_0000_0000_0000_0001, 128'h0F0F_0000_0000_0000_0000_0000_0000_0000};
        stall_beat = 1; stall_left = 2; stall_seen = 0;
        d_addr = 36'h0_0000_6000; d_we = 1; d_wdata = wd; d_req = 1;
        serve(0, 36'h0_0000_6000, 1, wd, 0);
        check("t3_stalls", 512'(stall_seen), 512'(2));
        check("t3_hold", 512'(hold_bad), 512'(0));
        stall_beat = -1;

        // Icache read with returns held back until well after the last beat.
        hold_ret = 1;
        a1 = 36'h0_0000_6000; i_addr = a1; i_req = 1;
        for (n = 0; n < 50 && log_q.size() != 4; n++) @(posedge clk);
        check("t4_issued", 512'(log_q.size()), 512'(4));
        early = 0;
        repeat (5) begin
            @(negedge clk);
            if (i_done || d_done) early = 1;
        end
        check("t4_no_early_done", 512'(early), 512'(0));
        hold_ret = 0;
        serve(1, a1, 0, '0, 0);
        check("t4_roundtrip", i_rdata, wd);
        stray_rv = 1;
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (i_done || d_done || mem_valid) early = 1;
        end
        stray_rv = 0;
        check("t4_stray_quiet", 512'(early), 512'(0));
        check("t4_stray_i", i_rdata, exp_i);
        check("t4_stray_d", d_rdata, exp_d);

        // Dcache request dropped after the first beat still completes.
        a2 = 36'h8_0000_0040; d_addr = a2; d_we = 0; d_req = 1;
        for (n = 0; n < 50 && log_q.size() != 1; n++) @(posedge clk);
        #1 d_req = 0;
        serve(0, a2, 0, '0, 0);

        // Reset during beat 2 of a dcache read.
        a2 = 36'h0_0000_7000; d_addr = a2; d_we = 0; d_req = 1;
        for (n = 0; n < 50 && log_q.size() != 2; n++) @(posedge clk);
        #1;
        check("t5_beat2_valid", 512'(mem_valid), 512'(1));
        check("t5_beat2_addr", 512'(mem_addr), 512'(36'h0_0000_7020));
        rst = 1; d_req = 0;
        #1;
        check("t5_rst_valid", 512'(mem_valid), 512'(0));
        check("t5_rst_addr", 512'(mem_addr), 512'(0));
        check("t5_rst_done", 512'(i_done || d_done), 512'(0));
        check("t5_rst_i_rdata", i_rdata, 512'(0));
        check("t5_rst_d_rdata", d_rdata, 512'(0));
        check("t5_rst_stall", 512'(caches_stall), 512'(0));
        rq.delete(); log_q.delete();
        exp_i = '0; exp_d = '0; last_i = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        early = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_done || i_done) early = 1;
        end
        check("t5_no_done", 512'(early), 512'(0));
        a1 = 36'h0_0000_1000; i_addr = a1; i_req = 1;
        serve(1, a1, 0, '0, 5);

        // Randomised traffic against the memory and arbitration model.
        ready_rand = 1; ret_rand = 1;
        for (int t = 0; t < 16; t++) begin
            int          kind;
            bit          we;
            logic [35:0] ia, da;
            kind = int'($urandom_range(3));
            we   = 1'($urandom_range(1));
            ia   = pool[$urandom_range(3)] | 36'($urandom_range(63));
            da   = pool[$urandom_range(3)] | 36'($urandom_range(63));
            wd   = rand_line();
            i_addr = ia; d_addr = da; d_we = we; d_wdata = wd;
            if (kind == 0) begin
                i_req = 1;
                serve(1, ia, 0, '0, 0);
            end else if (kind == 1) begin
                d_req = 1;
                serve(0, da, we, wd, 0);
            end else begin
                i_req = 1; d_req = 1;
                if (last_i) begin
                    serve(0, da, we, wd, 0);
                    serve(1, ia, 0, '0, 0);
                end else begin
                    serve(1, ia, 0, '0, 0);
                    serve(0, da, we, wd, 0);
                end
            end
        end
        check("hold_stable", 512'(hold_bad), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
